// File: rtl/svm_dot_engine.sv
// svm_dot_engine: multi-lane signed MAC producing one biased dot product per support vector
// against a held test vector, with valid/ready handshakes and optional saturation.
module svm_dot_engine #(
   parameter int DATA_SIZE  = 16,
   parameter int ACCUM_SIZE = 48,
   parameter int NUM_FEAT   = 8,
   parameter int NUM_LANES  = 2,
   parameter int SATURATE   = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           vec_valid,
   output logic                           vec_ready,
   input  logic [NUM_FEAT*DATA_SIZE-1:0]  vec_data,
   input  logic [ACCUM_SIZE-1:0]          accum_in,
   input  logic                           sv_valid,
   output logic                           sv_ready,
   input  logic [NUM_LANES*DATA_SIZE-1:0] sv_data,
   input  logic                           sv_last,
   input  logic                           sv_eov,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [ACCUM_SIZE-1:0]          res_data,
   output logic                           res_ovf,
   output logic                           err
);
   localparam int NUM_BEATS = NUM_FEAT / NUM_LANES;
   localparam int BW        = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1;
   localparam int EXT       = ACCUM_SIZE + $clog2(NUM_LANES) + 2;
   localparam int PW        = 2 * DATA_SIZE;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);
   localparam logic signed [EXT-1:0] MAX_V = {{(EXT-ACCUM_SIZE+1){1'b0}}, {(ACCUM_SIZE-1){1'b1}}};
   localparam logic signed [EXT-1:0] MIN_V = {{(EXT-ACCUM_SIZE+1){1'b1}}, {(ACCUM_SIZE-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

   state_t                          state_q, state_d;
   logic [BW-1:0]                   beat_q, beat_d;
   logic [NUM_FEAT*DATA_SIZE-1:0]   vec_q, vec_d;
   logic [ACCUM_SIZE-1:0]           bias_q, bias_d;
   logic [ACCUM_SIZE-1:0]           acc_q, acc_d;
   logic                            ovf_q, ovf_d;
   logic                            eov_q, eov_d;
   logic                            res_valid_q, res_valid_d;
   logic [ACCUM_SIZE-1:0]           res_data_q, res_data_d;
   logic                            res_ovf_q, res_ovf_d;
   logic                            err_q, err_d;

   logic signed [PW-1:0]            prod;
   logic signed [EXT-1:0]           lane_sum, sum;
   logic                            ovf_now;
   logic [ACCUM_SIZE-1:0]           red;
   logic                            final_beat;

   assign vec_ready = state_q == IDLE;
   assign sv_ready  = state_q == RUN;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_ovf   = res_ovf_q;
   assign err       = err_q;
   assign final_beat = beat_q == LAST_BEAT;

   // Sum is held wide enough that neither the lane sum nor the accumulate can wrap before f().
   always_comb begin
      lane_sum = '0;
      prod     = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         prod = $signed(vec_q[(int'(beat_q) * NUM_LANES + i) * DATA_SIZE +: DATA_SIZE])
              * $signed(sv_data[i * DATA_SIZE +: DATA_SIZE]);
         lane_sum = lane_sum + {{(EXT-PW){prod[PW-1]}}, prod};
      end
      sum     = {{(EXT-ACCUM_SIZE){acc_q[ACCUM_SIZE-1]}}, acc_q} + lane_sum;
      ovf_now = (sum > MAX_V) || (sum < MIN_V);
      red     = (SATURATE != 0 && ovf_now) ? (sum[EXT-1] ? MIN_V[ACCUM_SIZE-1:0] : MAX_V[ACCUM_SIZE-1:0])
                                           : sum[ACCUM_SIZE-1:0];
   end

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      vec_d       = vec_q;
      bias_d      = bias_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      eov_d       = eov_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_ovf_d   = res_ovf_q;
      err_d       = err_q;
      if (state_q == IDLE && vec_valid) begin
         vec_d   = vec_data;
         bias_d  = accum_in;
         acc_d   = accum_in;
         beat_d  = '0;
         ovf_d   = 1'b0;
         state_d = RUN;
      end
      if (state_q == RUN && sv_valid) begin
         acc_d  = red;
         beat_d = beat_q + 1'b1;
         ovf_d  = ovf_q | ovf_now;
         err_d  = err_q | (final_beat != sv_last);
         if (final_beat) begin
            res_data_d  = red;
            res_ovf_d   = ovf_q | ovf_now;
            res_valid_d = 1'b1;
            eov_d       = sv_eov;
            state_d     = OUT;
         end
      end
      if (state_q == OUT && res_ready) begin
         res_valid_d = 1'b0;
         acc_d       = bias_q;
         beat_d      = '0;
         ovf_d       = 1'b0;
         state_d     = eov_q ? IDLE : RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         vec_q       <= '0;
         bias_q      <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         eov_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_ovf_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         vec_q       <= vec_d;
         bias_q      <= bias_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         eov_q       <= eov_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_ovf_q   <= res_ovf_d;
         err_q       <= err_d;
      end
   end
endmodule

// File: tb/tb_svm_dot_engine.sv
// tb_svm_dot_engine: directed scoreboard bench driving a saturating and a wrapping engine in lockstep.
module tb_svm_dot_engine;
   localparam int DS = 16;
   localparam int A  = 32;
   localparam int NF = 4;
   localparam int NL = 2;
   localparam longint MAXL = 64'sh7FFFFFFF;
   localparam longint MINL = -64'sh80000000;

   logic clk = 1'b0, rst_n = 1'b0;
   logic vec_valid = 1'b0, sv_valid = 1'b0, sv_last = 1'b0, sv_eov = 1'b0, res_ready = 1'b1;
   logic [NF*DS-1:0] vec_data = '0;
   logic [A-1:0]     accum_in = '0;
   logic [NL*DS-1:0] sv_data  = '0;
   logic s_vec_ready, s_sv_ready, s_res_valid, s_res_ovf, s_err;
   logic w_vec_ready, w_sv_ready, w_res_valid, w_res_ovf, w_err;
   logic [A-1:0] s_res_data, w_res_data;

   svm_dot_engine #(.DATA_SIZE(DS), .ACCUM_SIZE(A), .NUM_FEAT(NF), .NUM_LANES(NL), .SATURATE(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_ready(s_vec_ready), .vec_data(vec_data),
      .accum_in(accum_in), .sv_valid(sv_valid), .sv_ready(s_sv_ready), .sv_data(sv_data),
      .sv_last(sv_last), .sv_eov(sv_eov), .res_valid(s_res_valid), .res_ready(res_ready),
      .res_data(s_res_data), .res_ovf(s_res_ovf), .err(s_err));

   svm_dot_engine #(.DATA_SIZE(DS), .ACCUM_SIZE(A), .NUM_FEAT(NF), .NUM_LANES(NL), .SATURATE(0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_ready(w_vec_ready), .vec_data(vec_data),
      .accum_in(accum_in), .sv_valid(sv_valid), .sv_ready(w_sv_ready), .sv_data(sv_data),
      .sv_last(sv_last), .sv_eov(sv_eov), .res_valid(w_res_valid), .res_ready(res_ready),
      .res_data(w_res_data), .res_ovf(w_res_ovf), .err(w_err));

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int vec_m[4];
   int sv_m[4];
   longint bias_m;
   logic [65:0] sb[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] model(input bit sat);
      longint acc, sum;
      bit o;
      acc = bias_m;
      o = 1'b0;
      for (int b = 0; b < 2; b++) begin
         sum = acc + longint'(vec_m[2*b]) * sv_m[2*b] + longint'(vec_m[2*b+1]) * sv_m[2*b+1];
         if (sum > MAXL || sum < MINL) o = 1'b1;
         acc = sat ? (sum > MAXL ? MAXL : (sum < MINL ? MINL : sum)) : longint'(int'(sum));
      end
      return {o, acc[31:0]};
   endfunction

   task automatic load_vec();
      int n = 0;
      for (int i = 0; i < NF; i++) vec_data[i*DS +: DS] = 16'(vec_m[i]);
      accum_in  = bias_m[A-1:0];
      vec_valid = 1'b1;
      while (!s_vec_ready && n < 50) begin step(); n++; end
      if (n >= 50) chk("vec_timeout", 64'(s_vec_ready), 64'd1);
      step();
      vec_valid = 1'b0;
   endtask

   task automatic send(input int a, input int b, input bit last, input bit eov);
      int n = 0;
      sv_data  = {16'(b), 16'(a)};
      sv_last  = last;
      sv_eov   = eov;
      sv_valid = 1'b1;
      while (!s_sv_ready && n < 50) begin step(); n++; end
      if (n >= 50) chk("sv_timeout", 64'(s_sv_ready), 64'd1);
      step();
      sv_valid = 1'b0;
   endtask

   task automatic run_sv(input bit last1, input bit eov);
      sb.push_back({model(1'b1), model(1'b0)});
      send(sv_m[0], sv_m[1], last1, 1'b0);
      send(sv_m[2], sv_m[3], 1'b1, eov);
   endtask

   task automatic collect(input string tag);
      int n = 0;
      logic [65:0] e;
      while (!(s_res_valid && res_ready) && n < 50) begin step(); n++; end
      if (n >= 50) chk({tag, "_res_timeout"}, 64'(s_res_valid), 64'd1);
      if (sb.size() == 0) begin
         bad++;
         $error("FAIL %s_sb_empty observed=result expected=none", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_sat_data"}, 64'(s_res_data), 64'(e[64:33]));
         chk({tag, "_sat_ovf"},  64'(s_res_ovf),  64'(e[65]));
         chk({tag, "_wrap_data"}, 64'(w_res_data), 64'(e[31:0]));
         chk({tag, "_wrap_ovf"},  64'(w_res_ovf),  64'(e[32]));
      end
      step();
   endtask

   initial begin
      step();
      step();
      chk("rst_res_valid", 64'(s_res_valid), 64'd0);
      chk("rst_res_data", 64'(s_res_data), 64'd0);
      chk("rst_err", 64'(s_err), 64'd0);
      chk("rst_vec_ready", 64'(s_vec_ready), 64'd1);
      chk("rst_sv_ready", 64'(s_sv_ready), 64'd0);
      rst_n = 1'b1;
      step();
      // basic dot product with bias
      vec_m = '{1, 2, 3, 4}; bias_m = 10; sv_m = '{5, 6, 7, 8};
      load_vec();
      chk("t1_vec_ready_run", 64'(s_vec_ready), 64'd0);
      run_sv(1'b0, 1'b1);
      chk("t1_latency", 64'(s_res_valid), 64'd1);
      chk("t1_sat_model", 64'(s_res_data), 64'd80);
      collect("t1");
      chk("t1_idle", 64'(s_vec_ready), 64'd1);
      chk("t1_res_valid_low", 64'(s_res_valid), 64'd0);
      chk("t1_err", 64'(s_err), 64'd0);
      // two SVs against one vector, results in order
      vec_m = '{-3, 2, 0, -1}; bias_m = 0; sv_m = '{4, -5, 9, 2};
      load_vec();
      run_sv(1'b0, 1'b0);
      chk("t2_vec_ready_out", 64'(s_vec_ready), 64'd0);
      collect("t2a");
      chk("t2_vec_ready_between", 64'(s_vec_ready), 64'd0);
      sv_m = '{1, 1, 1, 1};
      run_sv(1'b0, 1'b1);
      collect("t2b");
      chk("t2_vec_ready_end", 64'(s_vec_ready), 64'd1);
      // overflow: saturating clamps, wrapping keeps low bits
      vec_m = '{1, 1, 1, 1}; bias_m = 64'h7FFFFFF0; sv_m = '{16, 16, 0, 0};
      load_vec();
      run_sv(1'b0, 1'b1);
      chk("t3_sat_clamp", 64'(s_res_data), 64'h7FFFFFFF);
      chk("t3_wrap_low", 64'(w_res_data), 64'h80000010);
      collect("t3");
      // result backpressure stalls the SV stream
      vec_m = '{1, 2, 3, 4}; bias_m = 0; sv_m = '{1, 1, 1, 1};
      res_ready = 1'b0;
      load_vec();
      run_sv(1'b0, 1'b0);
      sv_data = {16'd0, 16'd2}; sv_last = 1'b0; sv_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("t4_sv_ready_stall", 64'(s_sv_ready), 64'd0);
         chk("t4_res_valid_hold", 64'(s_res_valid), 64'd1);
         chk("t4_res_data_hold", 64'(s_res_data), 64'd10);
         step();
      end
      res_ready = 1'b1;
      collect("t4a");
      chk("t4_restart", 64'(s_sv_ready), 64'd1);
      sv_m = '{2, 0, 0, 3};
      run_sv(1'b0, 1'b1);
      collect("t4b");
      // sv_last early sets sticky err, result still at counted boundary
      vec_m = '{1, 2, 3, 4}; bias_m = 10; sv_m = '{5, 6, 7, 8};
      load_vec();
      chk("t5_err_before", 64'(s_err), 64'd0);
      run_sv(1'b1, 1'b1);
      chk("t5_err_set", 64'(s_err), 64'd1);
      collect("t5");
      chk("t5_err_sticky", 64'(s_err), 64'd1);
      // async reset mid-SV
      load_vec();
      send(5, 6, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t6_res_valid", 64'(s_res_valid), 64'd0);
      chk("t6_res_data", 64'(s_res_data), 64'd0);
      chk("t6_res_ovf", 64'(s_res_ovf), 64'd0);
      chk("t6_err", 64'(s_err), 64'd0);
      chk("t6_vec_ready", 64'(s_vec_ready), 64'd1);
      chk("t6_sv_ready", 64'(s_sv_ready), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      load_vec();
      run_sv(1'b0, 1'b1);
      chk("t6_rerun_data", 64'(s_res_data), 64'd80);
      collect("t6");
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
